// File: rtl/stage_sequencer_if.sv
// Program-load port of the stage sequencer: a valid/ready word stream in,
// and the matching program-memory write strobe, address and data out.
interface stage_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
);
  // Handshake: a word transfers on a cycle where i_Load_valid and
  // o_Load_ready are both high. i_Load_last is only meaningful on that
  // cycle. o_Load_we marks the same cycle toward program memory.
  logic               i_Load_valid;
  logic [INSTR_W-1:0] i_Load_data;
  logic               i_Load_last;
  logic               o_Load_ready;
  logic               o_Load_we;
  logic [ADDR_W-1:0]  o_Load_addr;
  logic [INSTR_W-1:0] o_Load_instr;

  modport master (
    output i_Load_valid, i_Load_data, i_Load_last,
    input  o_Load_ready, o_Load_we, o_Load_addr, o_Load_instr
  );

  modport slave (
    input  i_Load_valid, i_Load_data, i_Load_last,
    output o_Load_ready, o_Load_we, o_Load_addr, o_Load_instr
  );
endinterface

// File: rtl/stage_sequencer.sv
// Four-stage microcontroller sequencer: LOAD streams the program into memory,
// then FETCH/DECODE/EXECUTE repeats with stall, reload and a retire counter.
module stage_sequencer #(
  parameter int PMEM_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 12
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  stage_sequencer_if.slave  load,
  input  logic              i_Stall,
  input  logic              i_Reload,
  output logic [1:0]        o_Stage,
  output logic [ADDR_W:0]   o_Prog_len,
  output logic [15:0]       o_Retired,
  output logic              o_Reload_pending
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'b00,
    ST_FETCH   = 2'b01,
    ST_DECODE  = 2'b10,
    ST_EXECUTE = 2'b11
  } stage_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(PMEM_DEPTH - 1);

  stage_t             stage_q, stage_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    plen_q, plen_d;
  logic [15:0]        retired_q, retired_d;
  logic               pending_q, pending_d;
  logic               accept;
  logic               reload_now;
  logic [INSTR_W-1:0] word;

  assign word       = load.i_Load_data;
  assign reload_now = pending_q | i_Reload;

  always_comb begin
    stage_d   = stage_q;
    addr_d    = addr_q;
    plen_d    = plen_q;
    retired_d = retired_q;
    pending_d = pending_q;
    accept    = 1'b0;

    case (stage_q)
      ST_LOAD: begin
        accept = load.i_Load_valid & ~i_Rst;
        if (accept) begin
          plen_d = {1'b0, addr_q} + (ADDR_W+1)'(1);
          // The last memory slot ends the load regardless of i_Load_last,
          // and the address parks there instead of wrapping.
          if (addr_q == ADDR_MAX) begin
            stage_d = ST_FETCH;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (load.i_Load_last) stage_d = ST_FETCH;
          end
        end
      end
      ST_FETCH:  if (!i_Stall) stage_d = ST_DECODE;
      ST_DECODE: if (!i_Stall) stage_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (!i_Stall) begin
          retired_d = retired_q + 16'd1;
          if (reload_now) begin
            stage_d = ST_LOAD;
            addr_d  = '0;
            plen_d  = '0;
          end else begin
            stage_d = ST_FETCH;
          end
        end
      end
      default: stage_d = ST_LOAD;
    endcase

    // A reload request is remembered until an unstalled EXECUTE consumes it.
    if (stage_q != ST_LOAD && i_Reload) pending_d = 1'b1;
    if (stage_q == ST_EXECUTE && !i_Stall && reload_now) pending_d = 1'b0;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      stage_q   <= ST_LOAD;
      addr_q    <= '0;
      plen_q    <= '0;
      retired_q <= '0;
      pending_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      addr_q    <= addr_d;
      plen_q    <= plen_d;
      retired_q <= retired_d;
      pending_q <= pending_d;
    end
  end

  assign load.o_Load_ready = (stage_q == ST_LOAD);
  assign load.o_Load_we    = accept;
  assign load.o_Load_addr  = addr_q;
  assign load.o_Load_instr = word;

  assign o_Stage          = stage_q;
  assign o_Prog_len       = plen_q;
  assign o_Retired        = retired_q;
  assign o_Reload_pending = pending_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: vector table, directed multi-cycle sequences and
// random stimulus checked against a queue-based behavioural model.
module tb_stage_sequencer;
  localparam int PMEM_DEPTH = 256;
  localparam int ADDR_W     = 8;
  localparam int INSTR_W    = 12;
  localparam int SB_W       = ADDR_W + INSTR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              reload;
  logic [1:0]        stage;
  logic [ADDR_W:0]   prog_len;
  logic [15:0]       retired;
  logic              pending;

  stage_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) lif ();

  stage_sequencer #(.PMEM_DEPTH(PMEM_DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .i_Clk            (clk),
    .i_Rst            (rst),
    .load             (lif.slave),
    .i_Stall          (stall),
    .i_Reload         (reload),
    .o_Stage          (stage),
    .o_Prog_len       (prog_len),
    .o_Retired        (retired),
    .o_Reload_pending (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_writes = 0;

  // Behavioural model: program held as a queue of accepted words, run loop as
  // a position 0..2 in the FETCH/DECODE/EXECUTE sequence.
  bit                 m_loading;
  int                 m_run_pos;
  logic [INSTR_W-1:0] m_words[$];
  int                 m_retired;
  bit                 m_pending;
  logic [SB_W-1:0]    exp_q[$];

  logic [1:0]        snap_stage;
  logic              snap_we, snap_ready, snap_pend;
  logic [ADDR_W-1:0] snap_addr;
  logic [ADDR_W:0]   snap_plen;
  logic [15:0]       snap_ret;

  typedef struct {
    bit v; logic [INSTR_W-1:0] d; bit l; bit s; bit r;
    logic [1:0] stage; bit we; logic [ADDR_W-1:0] addr; bit ready;
    logic [ADDR_W:0] plen; logic [15:0] ret; bit pend;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] m_addr();
    if (m_words.size() >= PMEM_DEPTH) return ADDR_W'(PMEM_DEPTH - 1);
    return ADDR_W'(m_words.size());
  endfunction

  task automatic model_reset();
    m_loading = 1'b1;
    m_run_pos = 0;
    m_words.delete();
    m_retired = 0;
    m_pending = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [INSTR_W-1:0] d, input bit l,
                            input bit s, input bit r);
    if (m_loading) begin
      if (v) begin
        m_words.push_back(d);
        if (l || m_words.size() == PMEM_DEPTH) begin
          m_loading = 1'b0;
          m_run_pos = 0;
        end
      end
    end else begin
      if (r) m_pending = 1'b1;
      if (!s) begin
        if (m_run_pos == 2) begin
          m_retired = (m_retired + 1) % 65536;
          if (m_pending) begin
            m_loading = 1'b1;
            m_pending = 1'b0;
            m_words.delete();
          end else begin
            m_run_pos = 0;
          end
        end else begin
          m_run_pos++;
        end
      end
    end
  endtask

  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit v, input logic [INSTR_W-1:0] d, input bit l,
                       input bit s, input bit r);
    logic [SB_W-1:0] got;
    lif.i_Load_valid = v;
    lif.i_Load_data  = d;
    lif.i_Load_last  = l;
    stall  = s;
    reload = r;
    #2;
    snap_stage = stage;      snap_we   = lif.o_Load_we;  snap_ready = lif.o_Load_ready;
    snap_addr  = lif.o_Load_addr; snap_plen = prog_len;  snap_ret = retired; snap_pend = pending;
    chk("stage",   32'(stage),   m_loading ? 32'd0 : 32'(m_run_pos + 1));
    chk("ready",   32'(lif.o_Load_ready), 32'(m_loading));
    chk("we",      32'(lif.o_Load_we),    32'(m_loading && v));
    chk("addr",    32'(lif.o_Load_addr),  32'(m_addr()));
    chk("instr",   32'(lif.o_Load_instr), 32'(d));
    chk("prog_len", 32'(prog_len), 32'(m_words.size()));
    chk("retired", 32'(retired),  32'(m_retired));
    chk("pending", 32'(pending),  32'(m_pending));
    if (m_loading && v) exp_q.push_back({m_addr(), d});
    if (lif.o_Load_we) begin
      dut_writes++;
      got = {lif.o_Load_addr, lif.o_Load_instr};
      if (exp_q.size() == 0) chk("write_unexpected", 32'(got), 32'hFFFF_FFFF);
      else chk("write_addr_data", 32'(got), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    model_step(v, d, l, s, r);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges must act at once, with valid held high.
  task automatic apply_reset(input string tag);
    lif.i_Load_valid = 1'b1;
    lif.i_Load_data  = 12'h3C3;
    lif.i_Load_last  = 1'b0;
    stall = 1'b0; reload = 1'b0;
    rst = 1'b1;
    #1;
    chk({tag, "_stage"},   32'(stage), 32'd0);
    chk({tag, "_addr"},    32'(lif.o_Load_addr), 32'd0);
    chk({tag, "_plen"},    32'(prog_len), 32'd0);
    chk({tag, "_retired"}, 32'(retired), 32'd0);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_ready"},   32'(lif.o_Load_ready), 32'd1);
    chk({tag, "_we"},      32'(lif.o_Load_we), 32'd0);
    chk({tag, "_instr"},   32'(lif.o_Load_instr), 32'h3C3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lif.i_Load_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    int w0;
    rst = 1'b1; stall = 1'b0; reload = 1'b0;
    lif.i_Load_valid = 1'b0; lif.i_Load_data = '0; lif.i_Load_last = 1'b0;
    model_reset();
    @(posedge clk); #1;
    apply_reset("rst0");

    //            v     d        l     s     r     stg   we    addr  rdy   plen  ret    pend
    tbl[0]  = '{1'b1, 12'h123, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0, 1'b1, 9'd0, 16'd0, 1'b0};
    tbl[1]  = '{1'b1, 12'h456, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd1, 1'b1, 9'd1, 16'd0, 1'b0};
    tbl[2]  = '{1'b1, 12'h789, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 8'd2, 1'b1, 9'd2, 16'd0, 1'b0};
    tbl[3]  = '{1'b1, 12'h0AA, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'd3, 1'b0, 9'd3, 16'd0, 1'b0};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 8'd3, 1'b0, 9'd3, 16'd0, 1'b0};
    tbl[5]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 8'd3, 1'b0, 9'd3, 16'd0, 1'b0};
    tbl[6]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 8'd3, 1'b0, 9'd3, 16'd1, 1'b0};
    tbl[7]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 8'd3, 1'b0, 9'd3, 16'd1, 1'b1};
    tbl[8]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 8'd3, 1'b0, 9'd3, 16'd1, 1'b1};
    tbl[9]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 8'd3, 1'b0, 9'd3, 16'd1, 1'b1};
    tbl[10] = '{1'b1, 12'h321, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0, 1'b1, 9'd0, 16'd2, 1'b0};
    tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1, 1'b0, 9'd1, 16'd2, 1'b0};
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].s, tbl[i].r);
      chk($sformatf("tbl%0d_stage", i), 32'(snap_stage), 32'(tbl[i].stage));
      chk($sformatf("tbl%0d_we", i),    32'(snap_we),    32'(tbl[i].we));
      chk($sformatf("tbl%0d_addr", i),  32'(snap_addr),  32'(tbl[i].addr));
      chk($sformatf("tbl%0d_ready", i), 32'(snap_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_plen", i),  32'(snap_plen),  32'(tbl[i].plen));
      chk($sformatf("tbl%0d_ret", i),   32'(snap_ret),   32'(tbl[i].ret));
      chk($sformatf("tbl%0d_pend", i),  32'(snap_pend),  32'(tbl[i].pend));
    end
    chk("tbl_sb_drain", 32'(exp_q.size()), 32'd0);

    // Valid gaps: only two writes.
    apply_reset("rst_gap");
    w0 = dut_writes;
    cycle(1'b1, 12'hA01, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 12'hBAD, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 12'hBAD, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 12'hA02, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    chk("gap_writes", 32'(dut_writes - w0), 32'd2);
    chk("gap_plen",   32'(snap_plen), 32'd2);
    chk("gap_stage",  32'(snap_stage), 32'd1);
    chk("gap_sb_drain", 32'(exp_q.size()), 32'd0);

    // Full memory without last; a 257th word is refused.
    apply_reset("rst_full");
    w0 = dut_writes;
    for (int i = 0; i < PMEM_DEPTH; i++)
      cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 12'h5A5, 1'b1, 1'b0, 1'b0);
    chk("full_writes", 32'(dut_writes - w0), 32'(PMEM_DEPTH));
    chk("full_stage",  32'(snap_stage), 32'd1);
    chk("full_ready",  32'(snap_ready), 32'd0);
    chk("full_we",     32'(snap_we), 32'd0);
    chk("full_addr",   32'(snap_addr), 32'hFF);
    chk("full_plen",   32'(snap_plen), 32'd256);
    chk("full_sb_drain", 32'(exp_q.size()), 32'd0);

    // Ten unstalled instructions, then a 2-cycle stall in DECODE.
    idle(2);
    idle(30);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("run10_retired", 32'(snap_ret), 32'd11);
    chk("run10_stage",   32'(snap_stage), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("stall_a", 32'(snap_stage), 32'd2);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("stall_b", 32'(snap_stage), 32'd2);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("stall_c", 32'(snap_stage), 32'd2);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("stall_exec", 32'(snap_stage), 32'd3);
    chk("stall_ret_held", 32'(snap_ret), 32'd11);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("stall_ret_after", 32'(snap_ret), 32'd12);

    // Reload pulse in FETCH returns to LOAD after EXECUTE.
    idle(2);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rl_fetch", 32'(snap_stage), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rl_pending", 32'(snap_pend), 32'd1);
    idle(1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rl_stage", 32'(snap_stage), 32'd0);
    chk("rl_addr",  32'(snap_addr), 32'd0);
    chk("rl_pend_clr", 32'(snap_pend), 32'd0);
    chk("rl_retired", 32'(snap_ret), 32'd14);
    chk("rl_plen", 32'(snap_plen), 32'd0);

    // Reset mid-DECODE, then mid-LOAD at address 5.
    cycle(1'b1, 12'h111, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    apply_reset("rst_decode");
    for (int i = 0; i < 5; i++) cycle(1'b1, 12'(i + 1), 1'b0, 1'b0, 1'b0);
    apply_reset("rst_load");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, 12'($urandom_range(0, 4095)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0);
    idle(1);
    chk("rand_sb_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Generates the four-stage microcontroller sequence (LOAD, FETCH, DECODE, EXECUTE) consumed by the control unit as its stage input. During LOAD it accepts the program one 12-bit word per cycle over a valid/ready handshake and presents the word and write address to program memory. After loading it cycles FETCH→DECODE→EXECUTE indefinitely, with stall and reload controls and a retired-instruction counter.

## Interface
- PMEM_DEPTH, 256: program memory depth in words; must be a power of two
- ADDR_W, 8: log2(PMEM_DEPTH)
- INSTR_W, 12: instruction width

- i_Clk  in  1  rising-edge clock
- i_Rst  in  1  reset; asynchronous and active-high
- i_Load_valid  in  1  program word present on i_Load_data
- i_Load_data  in  INSTR_W  program word
- i_Load_last  in  1  qualifies the current word as the final one
- o_Load_ready  out  1  sequencer can accept a word
- o_Load_we  out  1  program memory write strobe
- o_Load_addr  out  ADDR_W  program memory write address
- o_Load_instr  out  INSTR_W  program memory write data
- i_Stall  in  1  freeze the stage sequence while high
- i_Reload  in  1  request a return to LOAD (pulse or level)
- o_Stage  out  2  00 LOAD, 01 FETCH, 10 DECODE, 11 EXECUTE
- o_Prog_len  out  ADDR_W+1  number of words accepted in the last LOAD
- o_Retired  out  16  count of completed EXECUTE stages
- o_Reload_pending  out  1  reload request latched, not yet taken

## Operation
- Reset (async, any time): o_Stage=00, load address=0, o_Prog_len=0, o_Retired=0, o_Reload_pending=0. Combinationally: o_Load_ready=1, o_Load_we=0, o_Load_addr=0, o_Load_instr=i_Load_data.
- LOAD: o_Load_ready=1. Accept = i_Load_valid & o_Load_ready. o_Load_we=accept (combinational). o_Load_addr=registered load address; o_Load_instr=i_Load_data passthrough.
- On accept: load address increments, o_Prog_len=address+1. Exit to FETCH next cycle when the accepted word has i_Load_last=1, or the accepted address is PMEM_DEPTH-1 (memory full; i_Load_last ignored). Address is not allowed to wrap.
- Valid low in LOAD: no write, state held indefinitely.
- Outside LOAD: o_Load_ready=0, o_Load_we=0, o_Load_addr holds its last value.
- Run loop: FETCH→DECODE→EXECUTE→FETCH, one stage per cycle.
- i_Stall=1 in FETCH/DECODE/EXECUTE: o_Stage, o_Retired held; in LOAD, i_Stall ignored.
- o_Retired increments (wraps at 2^16) on each non-stalled cycle leaving EXECUTE.
- i_Reload sampled high in any non-LOAD cycle sets o_Reload_pending. When the sequencer leaves EXECUTE (non-stalled) with a pending reload (registered, or i_Reload high that cycle), the next stage is LOAD instead of FETCH. On that transition: load address=0, o_Prog_len=0, o_Reload_pending=0. The instruction still counts as retired. i_Reload in LOAD: ignored.
- Stall and reload together: stall wins; reload stays pending.
- o_Retired is not cleared by reload, only by reset.

## Timing
- o_Stage, o_Prog_len, o_Retired, o_Reload_pending: registered. o_Load_ready, o_Load_we, o_Load_instr: combinational from stage and inputs.
- Load throughput: one word per cycle. First FETCH occurs the cycle after the last accept.
- Unstalled instruction period: 3 cycles. Each stall cycle adds one.
- Reload latency: at most 3 cycles plus stall cycles from request to o_Stage=00.
- Reset release: first LOAD accept is possible on the first rising edge after i_Rst falls.

## Test plan
- Reset, load 3 words 0x123/0x456/0x789 back-to-back, last on the third -> o_Load_we pulses at addresses 0,1,2 with matching data. o_Prog_len=3. o_Stage=01 the following cycle.
- Load with valid gaps (valid 1,0,0,1 with last) -> exactly 2 writes at addresses 0,1. o_Prog_len=2. No write on gap cycles.
- Load 256 words with i_Load_last never asserted -> final write at address 0xFF. Stage becomes FETCH, o_Load_ready=0. A 257th valid word is not written.
- Run 10 unstalled instructions -> o_Stage repeats 01,10,11, and o_Retired=10 after 30 cycles. Stall high 2 cycles in DECODE -> o_Stage stays 10 for 3 cycles, retire count delayed 2 cycles.
- Pulse i_Reload during FETCH -> o_Reload_pending=1 next cycle. After EXECUTE, o_Stage=00, load address 0, pending cleared, o_Retired incremented by 1. Reload held with stall in EXECUTE -> stays in EXECUTE until stall drops.
- Assert i_Rst mid-DECODE and mid-LOAD (address 5) -> immediately o_Stage=00, address 0, o_Retired=0, o_Prog_len=0, pending=0.
